// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the multiply/divide unit
interface mdu_if #(parameter int W = 32);
  logic start, flush, ready, busy, done, div_zero;
  logic [5:0] funct;
  logic [W-1:0] rs, rt, hi, lo;
  modport master(output start, funct, rs, rt, flush, input ready, busy, done, div_zero, hi, lo);
  modport slave(input start, funct, rs, rt, flush, output ready, busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mdu_iterative.sv
// mdu_iterative: one-bit-per-cycle mult/multu/div/divu unit owning the HI/LO registers
module mdu_iterative #(
  parameter int W = 32,
  parameter int CW = 6
) (
  input logic clk,
  input logic reset,
  mdu_if.slave m
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [W-1:0] a, b, hi_r, lo_r, rsub, quo, rem;
  logic [2*W-1:0] acc, prod;
  logic [CW-1:0] cnt;
  logic [W:0] rsh;
  logic is_div, neg_q, neg_r, dz, done_r, dz_r, take, is_md, sgn, ge, commit;
  always_comb begin
    take = state == IDLE && m.start && !m.flush;
    is_md = m.funct[5:2] == 4'b0110;
    sgn = !m.funct[0];
    state_n = state == IDLE ? (take && is_md ? CALC : IDLE) :
              m.flush ? IDLE :
              state == CALC ? (cnt == CW'(1) ? FIX : CALC) : IDLE;
    commit = state == FIX && !m.flush;
    rsh = {acc[2*W-1:W], a[W-1]};
    ge = rsh >= {1'b0, b};
    rsub = rsh[W-1:0] - b;
    quo = neg_q ? -acc[W-1:0] : acc[W-1:0];
    rem = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
    prod = neg_q ? -acc : acc;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
      done_r <= 1'b0;
      dz_r <= 1'b0;
    end else begin
      done_r <= commit;
      dz_r <= commit && is_div && dz;
      if (take && m.funct == 6'b010001) hi_r <= m.rs;
      if (take && m.funct == 6'b010011) lo_r <= m.rs;
      if (take && is_md) begin
        a <= sgn && m.rs[W-1] ? -m.rs : m.rs;
        b <= sgn && m.rt[W-1] ? -m.rt : m.rt;
        acc <= '0;
        cnt <= CW'(W);
        is_div <= m.funct[1];
        neg_q <= sgn && (m.rs[W-1] ^ m.rt[W-1]);
        neg_r <= sgn && m.rs[W-1];
        dz <= m.rt == '0;
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
        if (is_div) begin
          acc <= {ge ? rsub : rsh[W-1:0], acc[W-2:0], ge};
          a <= a << 1;
        end else begin
          acc <= {acc[2*W-2:0], 1'b0} + (b[W-1] ? {{W{1'b0}}, a} : '0);
          b <= b << 1;
        end
      end
      if (commit) begin
        hi_r <= is_div ? rem : prod[2*W-1:W];
        lo_r <= is_div ? (dz ? '1 : quo) : prod[W-1:0];
      end
    end
  end
  assign m.ready = state == IDLE;
  assign m.busy = state != IDLE;
  assign m.done = done_r;
  assign m.div_zero = dz_r;
  assign m.hi = hi_r;
  assign m.lo = lo_r;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: randomized and directed checks of mdu_iterative against an arithmetic model
module tb_mdu_iterative;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi, exp_lo;
  mdu_if #(.W(32)) bus();
  mdu_iterative #(.W(32), .CW(6)) dut(.clk(clk), .reset(reset), .m(bus));
  always #5 clk = ~clk;
  function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sx, sy, p;
    longint unsigned ux, uy, up;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ux = longint'(x) & 64'hFFFF_FFFF;
    uy = longint'(y) & 64'hFFFF_FFFF;
    z = 1'b0;
    h = exp_hi;
    l = exp_lo;
    case (f)
      6'h18: begin p = sx * sy; {h, l} = p; end
      6'h19: begin up = ux * uy; {h, l} = up; end
      6'h1a, 6'h1b: begin
        if (y == 0) begin
          h = x;
          l = 32'hFFFF_FFFF;
          z = 1'b1;
        end else if (f == 6'h1a) begin
          l = 32'(sx / sy);
          h = 32'(sx % sy);
        end else begin
          l = 32'(ux / uy);
          h = 32'(ux % uy);
        end
      end
      default: ;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    int r;
    r = $urandom_range(0, 9);
    return r == 0 ? 32'h0 : r == 1 ? 32'h8000_0000 : r == 2 ? 32'hFFFF_FFFF : r == 3 ? 32'h1 : 32'($urandom);
  endfunction
  task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt);
    bus.start = 1'b1;
    bus.funct = f;
    bus.rs = x;
    bus.rt = y;
    lat = -1;
    bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask
  task automatic test_reset;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct = 6'h0;
    bus.rs = 32'h0;
    bus.rt = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    checks++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_ready ready=%b busy=%b exp 1/0", bus.ready, bus.busy); end
    checks++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_done done=%b dz=%b exp 0/0", bus.done, bus.div_zero); end
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    bus.start = 1'b1;
    bus.funct = 6'b100000;
    bus.rs = 32'h5555_AAAA;
    bus.rt = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL illegal_funct ready=%b done=%b exp 1/0", bus.ready, bus.done); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL illegal_funct hi=%h lo=%h exp 0/0", bus.hi, bus.lo); end
  endtask
  task automatic test_moves;
    bus.start = 1'b1;
    bus.funct = 6'b010001;
    bus.rs = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    exp_hi = 32'h1234;
    checks++; if (bus.hi !== 32'h1234 || bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL mthi hi=%h ready=%b done=%b exp 1234/1/0", bus.hi, bus.ready, bus.done); end
    bus.start = 1'b1;
    bus.funct = 6'b010011;
    bus.rs = 32'hCAFE_0001;
    @(negedge clk);
    exp_lo = 32'hCAFE_0001;
    checks++; if (bus.lo !== exp_lo || bus.hi !== exp_hi) begin errors++; $display("FAIL mtlo hi=%h lo=%h exp %h/%h", bus.hi, bus.lo, exp_hi, exp_lo); end
    bus.funct = 6'b010000;
    @(negedge clk);
    checks++; if (bus.lo !== exp_lo || bus.hi !== exp_hi || bus.busy !== 1'b0) begin errors++; $display("FAIL mfhi hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy); end
    bus.funct = 6'b010001;
    bus.rs = 32'hDEAD_BEEF;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++; if (bus.hi !== exp_hi) begin errors++; $display("FAIL flush_idle_mthi got=%h exp=%h", bus.hi, exp_hi); end
  endtask
  typedef struct {logic [5:0] f; logic [31:0] x, y, h, l; logic z;} vec_t;
  task automatic test_directed;
    vec_t v[6];
    int lat, bcnt;
    v[0] = '{6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    v[1] = '{6'h18, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    v[2] = '{6'h1a, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    v[3] = '{6'h1b, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    v[4] = '{6'h1a, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0};
    v[5] = '{6'h1b, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].f, v[i].x, v[i].y, lat, bcnt);
      checks++; if (lat !== 33) begin errors++; $display("FAIL directed%0d_latency got=%0d exp=33", i, lat); end
      checks++; if (bcnt !== 33) begin errors++; $display("FAIL directed%0d_busy_cycles got=%0d exp=33", i, bcnt); end
      checks++; if (bus.hi !== v[i].h || bus.lo !== v[i].l) begin errors++; $display("FAIL directed%0d_result hi=%h lo=%h exp %h/%h", i, bus.hi, bus.lo, v[i].h, v[i].l); end
      checks++; if (bus.div_zero !== v[i].z || bus.busy !== 1'b0) begin errors++; $display("FAIL directed%0d_flags dz=%b busy=%b exp %b/0", i, bus.div_zero, bus.busy, v[i].z); end
      exp_hi = v[i].h;
      exp_lo = v[i].l;
    end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin errors++; $display("FAIL pulse_width done=%b dz=%b exp 0/0", bus.done, bus.div_zero); end
  endtask
  task automatic test_flush;
    logic seen;
    for (int stop = 10; stop <= 32; stop += 22) begin
      bus.start = 1'b1;
      bus.funct = 6'h1a;
      bus.rs = 32'd1000;
      bus.rt = 32'd3;
      for (int k = 0; k <= stop; k++) begin
        @(negedge clk);
        bus.start = 1'b0;
      end
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL flush%0d_ready ready=%b done=%b exp 1/0", stop, bus.ready, bus.done); end
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush%0d_no_done got=%b exp=0", stop, seen); end
      checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin errors++; $display("FAIL flush%0d_keep hi=%h lo=%h exp %h/%h", stop, bus.hi, bus.lo, exp_hi, exp_lo); end
    end
  endtask
  task automatic test_busy_start;
    int lat;
    logic seen;
    bus.start = 1'b1;
    bus.funct = 6'h18;
    bus.rs = 32'hFFFF_FFF9;
    bus.rt = 32'd3;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.start = k >= 5 && k < 8;
      if (k == 5) begin
        bus.funct = 6'h19;
        bus.rs = 32'd100;
        bus.rt = 32'd100;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency got=%0d exp=33", lat); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL busy_start_result hi=%h lo=%h exp ffffffff/ffffffeb", bus.hi, bus.lo); end
    exp_hi = 32'hFFFF_FFFF;
    exp_lo = 32'hFFFF_FFEB;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_start_ignored got=%b exp=0", seen); end
  endtask
  task automatic test_back_to_back;
    logic [5:0] fs[4] = '{6'h18, 6'h19, 6'h1a, 6'h1b};
    logic [31:0] x, y, h, l;
    logic z;
    logic [5:0] f;
    int lat, bcnt, bad;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      f = fs[$urandom_range(0, 3)];
      x = pick();
      y = pick();
      model(f, x, y, h, l, z);
      run_op(f, x, y, lat, bcnt);
      checks++;
      if (lat !== 33 || bus.hi !== h || bus.lo !== l || bus.div_zero !== z) begin
        errors++;
        bad++;
        $display("FAIL random%0d f=%h rs=%h rt=%h lat=%0d hi=%h lo=%h dz=%b exp 33 %h/%h/%b", i, f, x, y, lat, bus.hi, bus.lo, bus.div_zero, h, l, z);
      end
      exp_hi = h;
      exp_lo = l;
      if (bad > 5) break;
    end
  endtask
  task automatic test_reset_mid;
    logic seen;
    bus.start = 1'b1;
    bus.funct = 6'h19;
    bus.rs = 32'h1234_5678;
    bus.rt = 32'h9ABC_DEF0;
    repeat (10) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.ready !== 1'b1) begin errors++; $display("FAIL reset_mid hi=%h lo=%h ready=%b exp 0/0/1", bus.hi, bus.lo, bus.ready); end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL reset_mid_no_done done_seen=%b hi=%h lo=%h exp 0/0/0", seen, bus.hi, bus.lo); end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_moves;
    test_directed;
    test_flush;
    test_busy_start;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multiply/divide unit for the MIPS datapath. It executes mult, multu, div and divu iteratively, one bit per cycle, and owns the architectural HI/LO registers.
- It also services mthi, mtlo, mfhi and mflo.
- It sits beside the ALU in the EX stage. The ALU control block hands R-type funct codes for these operations to this unit instead of the single-cycle ALU.
- The pipeline stalls on `busy`.

Parameters:
- `W`, default 32: operand width and HI/LO width. Legal range is 4 to 64.
- `CW`, default 6: width of the internal iteration counter. Must satisfy 2^CW > W.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request valid; carries the instruction in `funct`.
- `funct`  in  6  MIPS funct code.
- `rs`  in  W  operand A: multiplicand, dividend, or mthi/mtlo source.
- `rt`  in  W  operand B: multiplier or divisor.
- `flush`  in  1  cancel any in-flight operation; HI/LO are left unchanged.
- `ready`  out  1  high when the unit is in IDLE and can accept `start`.
- `busy`  out  1  inverse of `ready`; used as the pipeline stall request.
- `done`  out  1  one-cycle pulse when a mult/div result is committed to HI/LO.
- `div_zero`  out  1  one-cycle pulse, coincident with `done`, when a div/divu had `rt` = 0.
- `hi`  out  W  architectural HI register (mfhi read path).
- `lo`  out  W  architectural LO register (mflo read path).

Behaviour:
- Reset (synchronous, `reset`=1 at an edge) gives:
  - state=IDLE; `hi`=0; `lo`=0; `done`=0; `div_zero`=0; `busy`=0; `ready`=1.
  - Reset overrides `start` and `flush` in the same cycle. Reset mid-operation discards the operation.
- Funct decode, accepted only when `start`=1 and state=IDLE:
  - 011000 mult (signed)
  - 011001 multu
  - 011010 div (signed)
  - 011011 divu
  - 010001 mthi
  - 010011 mtlo
  - 010000 mfhi and 010010 mflo: no state change (read `hi`/`lo` directly).
  - Any other funct: ignored, no state change.
  - `start` while busy is ignored; the requester must hold it until `ready`.
- mthi/mtlo: `hi` (or `lo`) is loaded with `rs` at the accepting edge. State stays IDLE and `done` is not pulsed.
- State machine: IDLE -> CALC -> FIX -> IDLE.
  - IDLE -> CALC on an accepted mult/multu/div/divu edge. At this edge the unit:
    - latches |rs| and |rt| (absolute values for signed ops, raw values for unsigned);
    - latches the result-sign bits;
    - clears the 2W-bit accumulator;
    - sets counter = W.
  - CALC: one iteration per cycle, counter decrements, exit to FIX when the counter reaches 0 (exactly W cycles).
    - Multiply: shift-add.
    - Divide: restoring shift-subtract.
  - FIX: one cycle that applies the sign correction and writes the result.
    - Multiply: product negated if the signs differ. `hi` = upper W bits, `lo` = lower W bits.
    - Divide: quotient is negated if the signs of rs and rt differ; remainder takes the sign of rs. `lo` = quotient, `hi` = remainder.
    - `hi`/`lo` are written at the FIX->IDLE edge, and `done` is high for the following cycle.
- Latency: accept at edge E0; `busy`=1 in cycles E0 through E0+W+1. `hi`/`lo` are updated at edge E0+W+1, where `done`=1 and `busy`=0 (total W+1 cycles). A new `start` is accepted in the same cycle that `done` is high.
- Arithmetic rules:
  - Full 2W-bit product with no truncation.
  - Signed most-negative operands are handled via W+1-bit intermediate magnitudes.
  - div with -2^(W-1) / -1: `lo` = -2^(W-1) (wraps), `hi` = 0, no flag.
- Divide by zero (div or divu, `rt`=0): the full W-cycle latency still applies. Result is `lo` = all ones, `hi` = `rs` (raw), with `div_zero`=1 alongside `done`.
- `flush`:
  - In CALC or FIX: return to IDLE at the next edge; `hi`/`lo` unchanged; no `done`.
  - In IDLE: blocks acceptance that cycle, so no mthi/mtlo write occurs.
  - `flush` and the FIX->IDLE edge in the same cycle: the flush wins and no commit occurs.
- `hi`/`lo` change only on a commit, mthi/mtlo, or reset.

Test Plan (W=32):
- Reset then idle: after `reset`, `hi`=0, `lo`=0, `ready`=1, `done`=0. A `start` with funct 100000 leaves all state unchanged.
- multu 0xFFFFFFFF × 0xFFFFFFFF: `done` exactly 33 cycles after accept; `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high for the 33 intervening cycles.
- mult -7 × 3 gives `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. div -7 / 2 gives `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. divu 100 / 7 gives `lo`=14, `hi`=2.
- Boundaries:
  - div 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0.
  - divu 5 / 0 gives `lo`=0xFFFFFFFF, `hi`=5, `div_zero`=1 with `done`.
- `flush` at cycle 10 of a div: no `done`; `hi`/`lo` keep their prior values; `ready`=1 next cycle.
- Back-to-back and reset mid-op:
  - mthi 0x1234 when idle: `hi`=0x1234 next cycle.
  - `start` during busy is ignored.
  - `reset` mid-multiply: `hi`=`lo`=0, `done` never pulses.
